// File: rtl/rotary_pkg.sv
// rotary_pkg: shared direction/state types and step helpers for the rotary generator
package rotary_pkg;
    typedef enum logic {DIR_CW = 1'b0, DIR_CCW = 1'b1} dir_t;
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
    function automatic logic [7:0] step_pos(input logic [7:0] p, input dir_t d);
        return d == DIR_CCW ? p - 8'd1 : p + 8'd1;
    endfunction
endpackage

// File: rtl/rotary_timer.sv
// rotary_timer: loadable down-counter that stops at zero and flags it
module rotary_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    // load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/rotary_gen.sv
// rotary_gen: emits quadrature-style step pulses on one of two lines per command
module rotary_gen import rotary_pkg::*; #(
    parameter int PULSE_CYCLES = 2000000,
    parameter int GAP_CYCLES   = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_count,
    input  logic       abort,
    output logic [1:0] rotary_out,
    output logic [7:0] rotary_pos,
    output logic       busy,
    output logic       done
);
    localparam int TW = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0] P_LD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LD = TW'(GAP_CYCLES - 1);
    state_t state, state_n;
    dir_t dir, dir_n;
    logic [7:0] rem, rem_n, rem_eff, pos_n;
    logic [1:0] out_n;
    logic done_n, t_load, t_zero;
    logic [TW-1:0] t_val;
    rotary_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );
    // abort collapses the remaining step count to the one in flight
    assign rem_eff = abort ? 8'd1 : rem;
    // next state, timer reloads and next registered outputs
    always_comb begin
        state_n = state;
        dir_n   = dir;
        rem_n   = rem;
        pos_n   = rotary_pos;
        done_n  = 1'b0;
        t_load  = 1'b0;
        t_val   = '0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_count != 8'd0) begin
                        state_n = PULSE;
                        dir_n   = dir_t'(cmd_dir);
                        rem_n   = cmd_count;
                        pos_n   = step_pos(rotary_pos, dir_t'(cmd_dir));
                        t_load  = 1'b1;
                        t_val   = P_LD;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            PULSE: begin
                rem_n = rem_eff;
                if (t_zero) begin
                    state_n = GAP;
                    t_load  = 1'b1;
                    t_val   = G_LD;
                end
            end
            GAP: begin
                rem_n = rem_eff;
                if (t_zero) begin
                    rem_n = rem_eff - 8'd1;
                    if (rem_eff == 8'd1) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = PULSE;
                        pos_n   = step_pos(rotary_pos, dir);
                        t_load  = 1'b1;
                        t_val   = P_LD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        out_n = state_n == PULSE ? (dir_n == DIR_CCW ? 2'b10 : 2'b01) : 2'b00;
    end
    // state and registered outputs; ready comes up on the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dir        <= DIR_CW;
            rem        <= 8'd0;
            rotary_out <= 2'b00;
            rotary_pos <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            rem        <= rem_n;
            rotary_out <= out_n;
            rotary_pos <= pos_n;
            busy       <= state_n != IDLE;
            done       <= done_n;
            cmd_ready  <= state_n == IDLE;
        end
    end
endmodule

// File: doc/rotary_gen.md
ROTARY_GEN -- requirements
Module: rotary_gen

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 2000000, cycles one direction line is held high per step (legal range >= 1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2000000, cycles both lines are held low after each pulse (legal range >= 1).
REQ-003 The block SHALL have ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  step command offered
- cmd_ready  output  1  block accepts a command this cycle
- cmd_dir  input  1  0 = clockwise, 1 = counter-clockwise
- cmd_count  input  8  number of steps, 0..255
- abort  input  1  finish the current step, then stop
- rotary_out  output  2  bit0 = clockwise line, bit1 = counter-clockwise line
- rotary_pos  output  8  modelled position after emitted steps
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse

Function
REQ-004 The block SHALL use states IDLE, PULSE and GAP; every output SHALL be registered.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-006 On acceptance with cmd_count > 0, the block SHALL enter PULSE on the next cycle, latching cmd_dir and setting remaining = cmd_count.
REQ-007 In PULSE, rotary_out[dir] SHALL be 1 and the other bit 0 for exactly PULSE_CYCLES consecutive cycles; the state SHALL then go to GAP.
REQ-008 In GAP, rotary_out SHALL be 2'b00 for exactly GAP_CYCLES consecutive cycles.
REQ-009 At the end of GAP, remaining SHALL decrement; if the result is nonzero the block SHALL re-enter PULSE, otherwise it SHALL return to IDLE.
REQ-010 done SHALL be 1 for exactly the first IDLE cycle after a command completes.
REQ-011 rotary_pos SHALL change on the first cycle of each pulse: +1 for clockwise, -1 for counter-clockwise, modulo 256 (255+1 -> 0, 0-1 -> 255).
REQ-012 An accepted command with cmd_count = 0 SHALL produce done on the next cycle, leave rotary_out at 00, leave rotary_pos unchanged, and not assert busy.
REQ-013 busy SHALL be 1 in PULSE and GAP, and 0 in IDLE.
REQ-014 rotary_out SHALL never equal 2'b11.
REQ-015 abort in PULSE or GAP SHALL force remaining to 1, so the current pulse and gap complete in full (no truncated pulse) and then done is asserted.
REQ-016 abort in IDLE, including on a command-accept cycle, SHALL be ignored.
REQ-017 The step timer SHALL be sized to $clog2(max(PULSE_CYCLES, GAP_CYCLES)+1) bits with no overflow.

Reset
REQ-018 While rst_n = 0, the block SHALL immediately (asynchronously) force state IDLE, rotary_out = 00, rotary_pos = 0, busy = 0, done = 0 and remaining = 0.
REQ-019 cmd_ready SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-020 Reset mid-pulse SHALL drop rotary_out to 00 without waiting for a clock edge, and the interrupted command SHALL be discarded without a done pulse.

Structure
REQ-021 Shared package rotary_pkg SHALL hold the direction typedef (DIR_CW = 0, DIR_CCW = 1) and the state enum (IDLE, PULSE, GAP).
REQ-022 One sub-module, rotary_timer, SHALL implement a loadable down-counter with a zero flag; the FSM SHALL load it with PULSE_CYCLES-1 or GAP_CYCLES-1.

Verification
REQ-023 The bench SHALL run with PULSE_CYCLES = 4 and GAP_CYCLES = 3 and cover these scenarios:
- cw, count 3, from reset -> three 4-cycle bit0 pulses separated by 3-cycle gaps; rotary_pos 1, 2, 3; done 1 cycle; total busy = 21 cycles.
- ccw, count 2, from pos 1 -> pos 0 then 255; only bit1 ever high.
- cmd_count = 0 -> done on the next cycle; rotary_out stays 00; busy stays 0.
- count 5 with abort in the 2nd cycle of step 2 pulse -> step 2 completes in full (4+3 cycles); final pos 2; done once.
- rst_n low during a pulse -> rotary_out 00 asynchronously; pos 0; no done; cmd_ready 1 after release.
- cmd_valid held high across back-to-back commands -> second command accepted on the done cycle; no overlap; rotary_out never 11.
